// File: rtl/ofdm_cp_remover_if.sv
// Sample-stream handshake bundle: data, end marker and valid/ready.
interface ofdm_cp_remover_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] tdata;
  logic             tlast;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, tlast, tvalid, input tready);
  modport slave  (input tdata, tlast, tvalid, output tready);
endinterface

// File: rtl/ofdm_cp_remover.sv
// Cyclic-prefix remover: drops cp_len samples, passes sym_len samples closed by tlast.
// Optional zero padding of truncated symbols: define OFDM_CP_REMOVER_PAD_EN.
module ofdm_cp_remover #(
  parameter logic [7:0]  BASE    = 8'd0,
  parameter int          WIDTH   = 32,
  parameter logic [15:0] CP_DEF  = 16'd16,
  parameter logic [15:0] SYM_DEF = 16'd64
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              clear,
  input  logic              set_stb,
  input  logic [7:0]        set_addr,
  input  logic [31:0]       set_data,
  ofdm_cp_remover_if.slave  in_i,
  ofdm_cp_remover_if.master out_o,
  output logic              o_trunc
);

`ifdef OFDM_CP_REMOVER_PAD_EN
  typedef enum logic [1:0] {S_CP, S_SYM, S_PAD} state_t;
`else
  typedef enum logic [0:0] {S_CP, S_SYM} state_t;
`endif

  state_t           state_q, state_d;
  logic [15:0]      cp_len_q, sym_len_q;
  logic [15:0]      cp_sh_q, cp_sh_d, sym_sh_q, sym_sh_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             frame_start_q, frame_start_d;
  logic [WIDTH-1:0] tdata_q, tdata_d;
  logic             tlast_q, tlast_d, tvalid_q, tvalid_d, trunc_q, trunc_d;

  logic        wr_cp, wr_sym, run, out_free, ready, pass, accept, last_sym;
  logic [15:0] cp_new, sym_raw, sym_new, cp_eff, sym_eff, sym_cnt;
  logic        unused_set_hi;

  assign unused_set_hi = ^set_data[31:16];
  assign wr_cp   = set_stb && (set_addr == BASE);
  assign wr_sym  = set_stb && (set_addr == BASE + 8'd1);
  // A write in the same cycle as frame start is bypassed into the shadow copy.
  assign cp_new  = wr_cp  ? set_data[15:0] : cp_len_q;
  assign sym_raw = wr_sym ? set_data[15:0] : sym_len_q;
  assign sym_new = (sym_raw == 16'd0) ? 16'd1 : sym_raw;
  assign cp_eff  = frame_start_q ? cp_new  : cp_sh_q;
  assign sym_eff = frame_start_q ? sym_new : sym_sh_q;
  assign run      = aresetn & ~clear;
  assign out_free = out_o.tready | ~tvalid_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    frame_start_d = frame_start_q;
    cp_sh_d       = cp_sh_q;
    sym_sh_d      = sym_sh_q;
    tdata_d       = tdata_q;
    tlast_d       = tlast_q;
    tvalid_d      = tvalid_q & ~out_o.tready;
    trunc_d       = 1'b0;
    ready         = 1'b0;
    pass          = 1'b0;
    sym_cnt       = 16'd0;
    last_sym      = 1'b0;

    case (state_q)
      S_CP: begin
        pass  = (cp_eff == 16'd0);
        ready = pass ? out_free : 1'b1;
      end
      S_SYM: begin
        pass    = 1'b1;
        ready   = out_free;
        sym_cnt = cnt_q;
      end
      default: ready = 1'b0;
    endcase
    ready  = ready & run;
    accept = in_i.tvalid & ready;

    if (accept) begin
      if (frame_start_q) begin
        cp_sh_d       = cp_eff;
        sym_sh_d      = sym_eff;
        frame_start_d = 1'b0;
      end
      if (!pass) begin
        if (in_i.tlast) begin
          cnt_d         = 16'd0;
          frame_start_d = 1'b1;
        end else if (cnt_q == cp_eff - 16'd1) begin
          cnt_d   = 16'd0;
          state_d = S_SYM;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end else begin
        last_sym = (sym_cnt == sym_eff - 16'd1);
        tdata_d  = in_i.tdata;
        tvalid_d = 1'b1;
        tlast_d  = last_sym;
        if (in_i.tlast) frame_start_d = 1'b1;
        if (last_sym) begin
          cnt_d   = 16'd0;
          state_d = S_CP;
        end else if (in_i.tlast) begin
          trunc_d = 1'b1;
`ifdef OFDM_CP_REMOVER_PAD_EN
          cnt_d   = sym_cnt + 16'd1;
          state_d = S_PAD;
`else
          tlast_d = 1'b1;
          cnt_d   = 16'd0;
          state_d = S_CP;
`endif
        end else begin
          cnt_d   = sym_cnt + 16'd1;
          state_d = S_SYM;
        end
      end
    end

`ifdef OFDM_CP_REMOVER_PAD_EN
    // Padding uses the shadow length of the frame that was truncated.
    if (state_q == S_PAD && out_free && run) begin
      tdata_d  = '0;
      tvalid_d = 1'b1;
      tlast_d  = (cnt_q == sym_sh_q - 16'd1);
      if (tlast_d) begin
        cnt_d   = 16'd0;
        state_d = S_CP;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      cp_len_q  <= CP_DEF;
      sym_len_q <= SYM_DEF;
    end else begin
      if (wr_cp)  cp_len_q  <= set_data[15:0];
      if (wr_sym) sym_len_q <= set_data[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn || clear) begin
      state_q       <= S_CP;
      cnt_q         <= 16'd0;
      frame_start_q <= 1'b1;
      cp_sh_q       <= 16'd0;
      sym_sh_q      <= 16'd0;
      tdata_q       <= '0;
      tlast_q       <= 1'b0;
      tvalid_q      <= 1'b0;
      trunc_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      frame_start_q <= frame_start_d;
      cp_sh_q       <= cp_sh_d;
      sym_sh_q      <= sym_sh_d;
      tdata_q       <= tdata_d;
      tlast_q       <= tlast_d;
      tvalid_q      <= tvalid_d;
      trunc_q       <= trunc_d;
    end
  end

  assign in_i.tready  = ready;
  assign out_o.tdata  = tdata_q;
  assign out_o.tlast  = tlast_q;
  assign out_o.tvalid = tvalid_q;
  assign o_trunc      = trunc_q;

endmodule

// File: tb/tb_ofdm_cp_remover.sv
// Scoreboard bench for ofdm_cp_remover; expected symbols are derived from frame geometry.
// Honours OFDM_CP_REMOVER_PAD_EN for the truncation expectations.
module tb_ofdm_cp_remover;
  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        clear = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = 8'd0;
  logic [31:0] set_data = 32'd0;
  logic        o_trunc;

  ofdm_cp_remover_if #(.WIDTH(WIDTH)) in_if ();
  ofdm_cp_remover_if #(.WIDTH(WIDTH)) out_if ();

  always #5 clk = ~clk;

  ofdm_cp_remover #(.BASE(8'd0), .WIDTH(WIDTH), .CP_DEF(16'd16), .SYM_DEF(16'd64)) dut (
    .clk      (clk),
    .aresetn  (aresetn),
    .clear    (clear),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data),
    .in_i     (in_if.slave),
    .out_o    (out_if.master),
    .o_trunc  (o_trunc)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          trunc_seen = 0;
  int          trunc_exp = 0;
  logic        rand_ready = 1'b0;
  int          cp_cur = 16;
  int          sym_cur = 64;
  logic        stall_prev = 1'b0;
  logic [31:0] held_data = '0;
  logic        held_last = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: a transfer completes at the next edge when valid & ready here.
  always @(negedge clk) begin
    if (out_if.tvalid && stall_prev) begin
      chk("hold_data", 64'(out_if.tdata), 64'(held_data));
      chk("hold_last", 64'(out_if.tlast), 64'(held_last));
    end
    if (out_if.tvalid && out_if.tready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 64'(out_if.tvalid), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_data", 64'(out_if.tdata), 64'(e.data));
        chk("out_last", 64'(out_if.tlast), 64'(e.last));
      end
    end
    stall_prev = out_if.tvalid && !out_if.tready;
    held_data  = out_if.tdata;
    held_last  = out_if.tlast;
    if (o_trunc) trunc_seen++;
  end

  initial begin
    out_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic write_reg(input logic [7:0] addr, input int val);
    set_stb  = 1'b1;
    set_addr = addr;
    set_data = 32'(val);
    @(posedge clk);
    #1;
    set_stb = 1'b0;
    if (addr == 8'd0) cp_cur = val; else sym_cur = val;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    int t;
    t = 0;
    in_if.tdata  = d;
    in_if.tlast  = last;
    in_if.tvalid = 1'b1;
    @(negedge clk);
    while (!in_if.tready) begin
      t++;
      if (t > 1000) begin
        chk("send_timeout", 64'(t), 64'd0);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_if.tvalid = 1'b0;
    in_if.tlast  = 1'b0;
  endtask

  // Expected output of one frame: position p within each (cp+sym) period is kept when p >= cp.
  task automatic push_frame(input int n, input int base);
    int   sym, per, p, pend;
    exp_t e;
    sym  = (sym_cur == 0) ? 1 : sym_cur;
    per  = cp_cur + sym;
    for (int k = 0; k < n; k++) begin
      p = k % per;
      if (p >= cp_cur) begin
        e.data = 32'(base + k);
        e.last = (p == per - 1);
`ifndef OFDM_CP_REMOVER_PAD_EN
        if (k == n - 1) e.last = 1'b1;
`endif
        exp_q.push_back(e);
      end
    end
    pend = (n - 1) % per;
    if (pend >= cp_cur && pend != per - 1) begin
      trunc_exp++;
`ifdef OFDM_CP_REMOVER_PAD_EN
      for (int z = 0; z <= per - 2 - pend; z++) begin
        e.data = 32'd0;
        e.last = (z == per - 2 - pend);
        exp_q.push_back(e);
      end
`endif
    end
  endtask

  task automatic send_frame(input int n, input int base, input int wr_at = -1, input int wr_val = 0);
    push_frame(n, base);
    $display("[TB] frame n=%0d base=%0d cp=%0d sym=%0d", n, base, cp_cur, sym_cur);
    for (int k = 0; k < n; k++) begin
      send(32'(base + k), k == n - 1);
      if (k == wr_at) write_reg(8'd1, wr_val);
    end
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_trunc"}, 64'(trunc_seen), 64'(trunc_exp));
  endtask

  initial begin
    in_if.tdata  = '0;
    in_if.tlast  = 1'b0;
    in_if.tvalid = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 64'(out_if.tvalid), 64'd0);
    chk("rst_tdata",  64'(out_if.tdata),  64'd0);
    chk("rst_tlast",  64'(out_if.tlast),  64'd0);
    chk("rst_trunc",  64'(o_trunc),       64'd0);
    chk("rst_tready", 64'(in_if.tready),  64'd0);
    @(posedge clk);
    #1;
    aresetn = 1'b1;

    // 1: three 240-sample frames, always ready
    write_reg(8'd0, 16);
    write_reg(8'd1, 64);
    for (int f = 0; f < 3; f++) send_frame(240, f * 1000);
    drain("t1");

    // 2: same stimulus with random backpressure
    rand_ready = 1'b1;
    for (int f = 0; f < 3; f++) send_frame(240, 10000 + f * 1000);
    drain("t2");
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 3: no prefix, four-sample symbols
    write_reg(8'd0, 0);
    write_reg(8'd1, 4);
    send_frame(8, 20000);
    drain("t3");

    // frame ending inside the prefix yields nothing; the following frame is unaffected
    write_reg(8'd0, 16);
    write_reg(8'd1, 64);
    send_frame(10, 21000);
    send_frame(80, 22000);
    drain("t3b");

    // 4: truncated symbol, then a normal frame
    write_reg(8'd0, 2);
    write_reg(8'd1, 8);
    send_frame(7, 30000);
    send_frame(10, 31000);
    drain("t4");

    // zero symbol length behaves as one
    write_reg(8'd0, 1);
    write_reg(8'd1, 0);
    send_frame(4, 32000);
    drain("t4b");

    // 5: mid-frame length write applies from the next frame
    write_reg(8'd0, 16);
    write_reg(8'd1, 64);
    send_frame(240, 40000, 100, 32);
    send_frame(240, 41000);
    drain("t5");

    // 6: reset mid-symbol while output valid
    write_reg(8'd0, 16);
    write_reg(8'd1, 64);
    for (int k = 0; k < 40; k++) begin
      exp_t e;
      if (k >= 16) begin
        e.data = 32'(50000 + k);
        e.last = 1'b0;
        exp_q.push_back(e);
      end
      send(32'(50000 + k), 1'b0);
    end
    aresetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_tvalid", 64'(out_if.tvalid), 64'd0);
    chk("t6_tready", 64'(in_if.tready),  64'd0);
    chk("t6_flushed", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    cp_cur  = 16;
    sym_cur = 64;
    send_frame(80, 60000);
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
